// File: rtl/wb_arbiter_rr2_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_rr2_if
// Brief    : Bus bundle for the two-master / one-slave Wishbone arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_arbiter_rr2_if;
    logic        m0_cyc_i, m1_cyc_i;
    logic        m0_stb_i, m1_stb_i;
    logic        m0_we_i,  m1_we_i;
    logic [31:0] m0_adr_i, m1_adr_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [31:0] m0_dat_i, m1_dat_i;
    logic        m0_ack_o, m1_ack_o;
    logic        m0_err_o, m1_err_o;
    logic        m0_rty_o, m1_rty_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i, s_rty_i;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    // Arbiter side.
    modport slave (
        input  m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
        input  m0_adr_i, m1_adr_i, m0_sel_i, m1_sel_i, m0_dat_i, m1_dat_i,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_rty_o, m1_rty_o,
        output m0_dat_o, m1_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        output gnt_o, timeout_o
    );

    // Environment side: both masters and the shared slave.
    modport master (
        output m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
        output m0_adr_i, m1_adr_i, m0_sel_i, m1_sel_i, m0_dat_i, m1_dat_i,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_rty_o, m1_rty_o,
        input  m0_dat_o, m1_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
        input  gnt_o, timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter_rr2.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_rr2
// Brief    : Round-robin, CYC-locked two-master Wishbone arbiter with watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter_rr2 #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic         clk,
    input  wire logic         reset,
    wb_arbiter_rr2_if.slave   bus
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] C_THRESH = CW'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_GNT0 = 2'b01;
    localparam logic [1:0] S_GNT1 = 2'b10;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          own0, own1;
    logic          own_cyc, own_stb, own_we;
    logic [31:0]   own_adr, own_dat;
    logic [3:0]    own_sel;
    logic          rsp_any, at_thresh, forced;
    logic          route_ack, route_err, route_rty;

    always_comb begin
        own0      = (state_q == S_GNT0);
        own1      = (state_q == S_GNT1);
        own_cyc   = (own0 & bus.m0_cyc_i) | (own1 & bus.m1_cyc_i);
        own_stb   = (own0 & bus.m0_stb_i) | (own1 & bus.m1_stb_i);
        own_we    = (own0 & bus.m0_we_i)  | (own1 & bus.m1_we_i);
        own_adr   = ({32{own0}} & bus.m0_adr_i) | ({32{own1}} & bus.m1_adr_i);
        own_sel   = ({4{own0}}  & bus.m0_sel_i) | ({4{own1}}  & bus.m1_sel_i);
        own_dat   = ({32{own0}} & bus.m0_dat_i) | ({32{own1}} & bus.m1_dat_i);
        rsp_any   = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
        // The strobe mask depends only on the count so there is no stb->ack->stb loop.
        at_thresh = (TIMEOUT_CYCLES > 0) && (cnt_q == C_THRESH);
        forced    = at_thresh & own_cyc & own_stb & ~rsp_any;
        route_ack = bus.s_ack_i & ~forced;
        route_err = bus.s_err_i | forced;
        route_rty = bus.s_rty_i & ~forced;
    end

    assign bus.s_cyc_o   = own_cyc;
    assign bus.s_stb_o   = own_stb & ~at_thresh;
    assign bus.s_we_o    = own_we;
    assign bus.s_adr_o   = own_adr;
    assign bus.s_sel_o   = own_sel;
    assign bus.s_dat_o   = own_dat;
    assign bus.m0_ack_o  = own0 & route_ack;
    assign bus.m0_err_o  = own0 & route_err;
    assign bus.m0_rty_o  = own0 & route_rty;
    assign bus.m1_ack_o  = own1 & route_ack;
    assign bus.m1_err_o  = own1 & route_err;
    assign bus.m1_rty_o  = own1 & route_rty;
    assign bus.m0_dat_o  = bus.s_dat_i;
    assign bus.m1_dat_o  = bus.s_dat_i;
    assign bus.gnt_o     = state_q;
    assign bus.timeout_o = forced;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                // On a tie the master that did not win last time is served.
                if (bus.m0_cyc_i && (!bus.m1_cyc_i || last_q)) begin
                    state_d = S_GNT0;
                    last_d  = 1'b0;
                end else if (bus.m1_cyc_i) begin
                    state_d = S_GNT1;
                    last_d  = 1'b1;
                end
            end
            S_GNT0: begin
                if (!bus.m0_cyc_i) begin
                    if (bus.m1_cyc_i) begin
                        state_d = S_GNT1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GNT1: begin
                if (!bus.m1_cyc_i) begin
                    if (bus.m0_cyc_i) begin
                        state_d = S_GNT0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if ((TIMEOUT_CYCLES > 0) && (state_d == state_q) && own_cyc && own_stb
            && !rsp_any && !at_thresh) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_rr2.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter_rr2
// Brief    : Directed scoreboard bench for wb_arbiter_rr2 (TIMEOUT_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_rr2;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_arbiter_rr2_if bus();

    wb_arbiter_rr2 #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0]  gnt;
        logic        s_cyc;
        logic        s_stb;
        logic        s_we;
        logic [31:0] s_adr;
        logic [3:0]  s_sel;
        logic [31:0] s_dat;
        logic [2:0]  m0_rsp;   // {rty, err, ack}
        logic [2:0]  m1_rsp;
        logic        tmo;
        logic [31:0] m0_dat;
        logic [31:0] m1_dat;
    } obs_t;

    obs_t        exp_q[$];
    obs_t        mon_exp, mon_act;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_word = 32'h0;

    function automatic obs_t sample();
        obs_t a;
        a.gnt    = bus.gnt_o;
        a.s_cyc  = bus.s_cyc_o;
        a.s_stb  = bus.s_stb_o;
        a.s_we   = bus.s_we_o;
        a.s_adr  = bus.s_adr_o;
        a.s_sel  = bus.s_sel_o;
        a.s_dat  = bus.s_dat_o;
        a.m0_rsp = {bus.m0_rty_o, bus.m0_err_o, bus.m0_ack_o};
        a.m1_rsp = {bus.m1_rty_o, bus.m1_err_o, bus.m1_ack_o};
        a.tmo    = bus.timeout_o;
        a.m0_dat = bus.m0_dat_o;
        a.m1_dat = bus.m1_dat_o;
        return a;
    endfunction

    // Monitor: the DUT presents a full bus view every cycle; compare it mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = sample();
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL bus_view check %0d @%0t: got %h required %h",
                         checks, $time, mon_act, mon_exp);
            end
        end
    end

    // stim = {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_rty, s_err, s_ack}
    // expv = {gnt[1:0], s_cyc, s_stb, m0{rty,err,ack}, m1{rty,err,ack}, timeout}
    task automatic row(input logic [7:0] stim, input logic [10:0] expv);
        obs_t e;
        @(posedge clk);
        #1;
        reset        = stim[7];
        bus.m0_cyc_i = stim[6];
        bus.m0_stb_i = stim[5];
        bus.m1_cyc_i = stim[4];
        bus.m1_stb_i = stim[3];
        bus.s_rty_i  = stim[2];
        bus.s_err_i  = stim[1];
        bus.s_ack_i  = stim[0];
        rd_word      = rd_word + 32'h0101_0101;
        bus.s_dat_i  = rd_word;
        e = '0;
        e.gnt   = expv[10:9];
        e.s_cyc = expv[8];
        e.s_stb = expv[7];
        case (expv[10:9])
            2'b01: begin
                e.s_we = 1'b1; e.s_adr = 32'h0000_0100; e.s_sel = 4'hF; e.s_dat = 32'hDEAD_BEEF;
            end
            2'b10: begin
                e.s_we = 1'b0; e.s_adr = 32'h0000_0200; e.s_sel = 4'h3; e.s_dat = 32'h1111_2222;
            end
            default: begin
                e.s_we = 1'b0; e.s_adr = 32'h0; e.s_sel = 4'h0; e.s_dat = 32'h0;
            end
        endcase
        e.m0_rsp = expv[6:4];
        e.m1_rsp = expv[3:1];
        e.tmo    = expv[0];
        e.m0_dat = rd_word;
        e.m1_dat = rd_word;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b1;
        bus.m0_adr_i = 32'h0000_0100; bus.m0_sel_i = 4'hF; bus.m0_dat_i = 32'hDEAD_BEEF;
        bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0;
        bus.m1_adr_i = 32'h0000_0200; bus.m1_sel_i = 4'h3; bus.m1_dat_i = 32'h1111_2222;
        bus.s_dat_i = 32'h0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;

        // Reset state, then a single m0 write with one-cycle grant latency.
        row(8'b1_00_00_000, 11'b00_00_000_000_0);
        row(8'b0_11_00_000, 11'b00_00_000_000_0);
        row(8'b0_11_00_000, 11'b01_11_000_000_0);
        row(8'b0_11_00_001, 11'b01_11_001_000_0);
        row(8'b0_00_00_000, 11'b01_00_000_000_0);
        row(8'b0_00_00_000, 11'b00_00_000_000_0);

        // Re-arm last-winner, then simultaneous requests alternate with direct handover.
        row(8'b1_00_00_000, 11'b00_00_000_000_0);
        row(8'b0_11_11_000, 11'b00_00_000_000_0);
        row(8'b0_11_11_001, 11'b01_11_001_000_0);
        row(8'b0_00_11_000, 11'b01_00_000_000_0);
        row(8'b0_11_11_001, 11'b10_11_000_001_0);
        row(8'b0_11_00_000, 11'b10_00_000_000_0);
        row(8'b0_11_11_001, 11'b01_11_001_000_0);
        row(8'b0_00_11_000, 11'b01_00_000_000_0);
        row(8'b0_11_11_001, 11'b10_11_000_001_0);
        row(8'b0_11_00_000, 11'b10_00_000_000_0);
        row(8'b0_11_11_001, 11'b01_11_001_000_0);
        row(8'b0_00_11_000, 11'b01_00_000_000_0);
        row(8'b0_00_11_001, 11'b10_11_000_001_0);
        row(8'b0_00_00_000, 11'b10_00_000_000_0);
        row(8'b0_00_00_000, 11'b00_00_000_000_0);

        // m0 locks the bus over four transfers (ack, ack, rty, err) while m1 waits.
        row(8'b0_11_00_000, 11'b00_00_000_000_0);
        row(8'b0_11_11_001, 11'b01_11_001_000_0);
        row(8'b0_10_11_000, 11'b01_10_000_000_0);
        row(8'b0_11_11_001, 11'b01_11_001_000_0);
        row(8'b0_11_11_100, 11'b01_11_100_000_0);
        row(8'b0_11_11_010, 11'b01_11_010_000_0);
        row(8'b0_00_11_000, 11'b01_00_000_000_0);
        row(8'b0_00_11_001, 11'b10_11_000_001_0);
        row(8'b0_00_00_000, 11'b10_00_000_000_0);
        row(8'b0_00_00_000, 11'b00_00_000_000_0);

        // Silent slave: forced err on the fifth strobe cycle, then a normal ack.
        row(8'b0_11_00_000, 11'b00_00_000_000_0);
        for (int i = 0; i < 4; i++) row(8'b0_11_00_000, 11'b01_11_000_000_0);
        row(8'b0_11_00_000, 11'b01_10_010_000_1);
        row(8'b0_11_00_000, 11'b01_11_000_000_0);
        row(8'b0_11_00_001, 11'b01_11_001_000_0);
        row(8'b0_00_00_000, 11'b01_00_000_000_0);
        row(8'b0_00_00_000, 11'b00_00_000_000_0);

        // Slave acks in the threshold cycle: the ack wins, no forced err.
        row(8'b0_11_00_000, 11'b00_00_000_000_0);
        for (int i = 0; i < 4; i++) row(8'b0_11_00_000, 11'b01_11_000_000_0);
        row(8'b0_11_00_001, 11'b01_10_001_000_0);
        row(8'b0_00_00_000, 11'b01_00_000_000_0);
        row(8'b0_00_00_000, 11'b00_00_000_000_0);

        // Reset while m1 owns the bus with a strobe outstanding; m0 wins afterwards.
        row(8'b0_11_11_000, 11'b00_00_000_000_0);
        row(8'b1_11_11_000, 11'b10_11_000_000_0);
        row(8'b1_11_11_000, 11'b00_00_000_000_0);
        row(8'b0_11_11_000, 11'b00_00_000_000_0);
        row(8'b0_11_11_001, 11'b01_11_001_000_0);
        row(8'b0_00_11_000, 11'b01_00_000_000_0);
        row(8'b0_00_11_001, 11'b10_11_000_001_0);
        row(8'b0_00_00_000, 11'b10_00_000_000_0);
        row(8'b0_00_00_000, 11'b00_00_000_000_0);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected views left unchecked, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
